match_scanner: RTL

Downstream consumer of the pattern-matching multiplier's 2N-bit OR-accumulated match vector. It captures one vector per start pulse, scans it LSB-first one bit position per cycle, and emits the index of every set bit over a valid/ready stream. When the scan finishes it pulses done and holds the total match count. It converts the multiplier's parallel result into a serial list of match positions for the reporting and control logic.

---
 rtl/pm_pkg.sv | 16 +
 rtl/match_scanner.sv | 113 +++++++++++
 2 files changed

// File: rtl/pm_pkg.sv
// Types and width constants shared by the pattern-matching multiplier and the match scanner.
package pm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StEmit,
    StDone
  } scan_state_e;

  localparam int unsigned DefaultN = 30;
  localparam int unsigned W        = 2 * DefaultN;
  localparam int unsigned IDX_W    = $clog2(W);
  localparam int unsigned CNT_W    = $clog2(W + 1);

endpackage

// File: rtl/match_scanner.sv
// Serialises an OR-accumulated match vector into an ascending stream of set-bit indices,
// then pulses done and holds the number of matches accepted.
module match_scanner
  import pm_pkg::*;
#(
  parameter int unsigned N     = DefaultN,
  parameter int unsigned IDX_W = $clog2(2 * N),
  parameter int unsigned CNT_W = $clog2(2 * N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2*N-1:0]   vec,
  output logic             busy,
  output logic             idx_valid,
  output logic [IDX_W-1:0] idx,
  input  logic             idx_ready,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned VecW = 2 * N;
  localparam logic [IDX_W-1:0] LastPtr = IDX_W'(VecW - 1);

  scan_state_e      state_q, state_d;
  logic [VecW-1:0]  vec_q, vec_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    count_d = count_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          vec_d   = vec;
          ptr_d   = '0;
          count_d = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (vec_q[ptr_q]) begin
          idx_d   = ptr_q;
          state_d = StEmit;
        end else if (ptr_q == LastPtr) begin
          state_d = StDone;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      StEmit: begin
        if (idx_ready) begin
          count_d = count_q + CNT_W'(1);
          if (ptr_q == LastPtr) begin
            state_d = StDone;
          end else begin
            ptr_d   = ptr_q + IDX_W'(1);
            state_d = StScan;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status outputs are decoded from the next state so they come straight off flops.
    busy_d  = (state_d != StIdle);
    valid_d = (state_d == StEmit);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign idx_valid = valid_q;
  assign idx       = idx_q;
  assign done      = done_q;
  assign count     = count_q;

endmodule
